// File: rtl/ysyx_23060201_arb.sv
// rtl/ysyx_23060201_arb.sv - IFU/LSU arbiter onto one memory port, one transaction outstanding.
// Define YSYX_23060201_ARB_RR_EN for round-robin arbitration; default is fixed LSU priority.
module ysyx_23060201_arb #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  ifu_req_valid,
  output logic                  ifu_req_ready,
  input  logic [ADDR_WIDTH-1:0] ifu_req_addr,
  output logic                  ifu_resp_valid,
  output logic [DATA_WIDTH-1:0] ifu_resp_data,

  input  logic                  lsu_req_valid,
  output logic                  lsu_req_ready,
  input  logic                  lsu_req_wen,
  input  logic [ADDR_WIDTH-1:0] lsu_req_addr,
  input  logic [DATA_WIDTH-1:0] lsu_req_wdata,
  input  logic [7:0]            lsu_req_wmask,
  output logic                  lsu_resp_valid,
  output logic [DATA_WIDTH-1:0] lsu_resp_data,

  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_wen,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic [DATA_WIDTH-1:0] mem_req_wdata,
  output logic [7:0]            mem_req_wmask,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_resp_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t                state;
  state_t                state_nxt;

  logic                  owner_lsu;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic [7:0]            lat_wmask;
  logic                  lat_wen;

  logic                  lsu_first;
  logic                  grant_lsu;
  logic                  grant_ifu;
  logic                  accept;
  logic                  resp_window;

`ifdef YSYX_23060201_ARB_RR_EN
  logic                  rr_favour_lsu;

  assign lsu_first = rr_favour_lsu;

  // Pointer favours whichever requester did not win the last accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_favour_lsu <= 1'b1;
    end else if (accept) begin
      rr_favour_lsu <= ifu_req_ready;
    end
  end
`else
  assign lsu_first = 1'b1;
`endif

  assign grant_lsu = lsu_req_valid && (!ifu_req_valid || lsu_first);
  assign grant_ifu = ifu_req_valid && !grant_lsu;
  assign accept    = ifu_req_ready || lsu_req_ready;

  always_comb begin
    state_nxt     = state;
    ifu_req_ready = 1'b0;
    lsu_req_ready = 1'b0;
    mem_req_valid = 1'b0;
    resp_window   = 1'b0;
    // Outputs are held quiet for the whole reset cycle, including the very first one.
    if (!rst) begin
      case (state)
        S_IDLE: begin
          lsu_req_ready = grant_lsu;
          ifu_req_ready = grant_ifu;
          if (grant_lsu || grant_ifu) begin
            state_nxt = S_REQ;
          end
        end
        S_REQ: begin
          mem_req_valid = 1'b1;
          if (mem_req_ready) begin
            resp_window = 1'b1;
            state_nxt   = mem_resp_valid ? S_IDLE : S_WAIT;
          end
        end
        S_WAIT: begin
          resp_window = 1'b1;
          if (mem_resp_valid) begin
            state_nxt = S_IDLE;
          end
        end
        default: begin
          state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      owner_lsu <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_wmask <= '0;
      lat_wen   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        owner_lsu <= lsu_req_ready;
        if (lsu_req_ready) begin
          lat_addr  <= lsu_req_addr;
          lat_wdata <= lsu_req_wdata;
          lat_wmask <= lsu_req_wmask;
          lat_wen   <= lsu_req_wen;
        end else begin
          lat_addr  <= ifu_req_addr;
          lat_wdata <= '0;
          lat_wmask <= '0;
          lat_wen   <= 1'b0;
        end
      end
    end
  end

  assign mem_req_addr  = lat_addr;
  assign mem_req_wdata = lat_wdata;
  assign mem_req_wmask = lat_wmask;
  assign mem_req_wen   = lat_wen;

  assign ifu_resp_valid = resp_window && mem_resp_valid && !owner_lsu;
  assign lsu_resp_valid = resp_window && mem_resp_valid && owner_lsu;
  assign ifu_resp_data  = mem_resp_data;
  assign lsu_resp_data  = mem_resp_data;

endmodule

// File: tb/tb_ysyx_23060201_arb.sv
// tb/tb_ysyx_23060201_arb.sv - self-checking bench for ysyx_23060201_arb with a transaction-level model.
// Honours YSYX_23060201_ARB_RR_EN to pick the expected arbitration policy.
module tb_ysyx_23060201_arb;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          ifu_req_valid, ifu_req_ready;
  logic [AW-1:0] ifu_req_addr;
  logic          ifu_resp_valid;
  logic [DW-1:0] ifu_resp_data;
  logic          lsu_req_valid, lsu_req_ready, lsu_req_wen;
  logic [AW-1:0] lsu_req_addr;
  logic [DW-1:0] lsu_req_wdata;
  logic [7:0]    lsu_req_wmask;
  logic          lsu_resp_valid;
  logic [DW-1:0] lsu_resp_data;
  logic          mem_req_valid, mem_req_ready, mem_req_wen;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_wdata;
  logic [7:0]    mem_req_wmask;
  logic          mem_resp_valid;
  logic [DW-1:0] mem_resp_data;

  always #5 clk = ~clk;

  ysyx_23060201_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_data(ifu_resp_data),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_wen(lsu_req_wen),
    .lsu_req_addr(lsu_req_addr), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_data(lsu_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_wen(mem_req_wen),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Model: one outstanding transaction, described by its record and progress flags.
  bit          m_busy, m_issued, m_owner_lsu, m_last_lsu;
  bit [AW-1:0] m_addr;
  bit [DW-1:0] m_wdata;
  bit [7:0]    m_wmask;
  bit          m_wen;
  bit          acc_ifu, acc_lsu;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic sample();
    bit lsu_first, e_gl, e_gi, e_mv, hs, win;
    @(negedge clk);
    acc_ifu = 1'b0;
    acc_lsu = 1'b0;
    if (rst) begin
      chk("rst_mem_req_valid", mem_req_valid, 0);
      chk("rst_ifu_resp_valid", ifu_resp_valid, 0);
      chk("rst_lsu_resp_valid", lsu_resp_valid, 0);
      m_busy = 0; m_issued = 0; m_last_lsu = 0; m_owner_lsu = 0;
      m_addr = 0; m_wdata = 0; m_wmask = 0; m_wen = 0;
    end else begin
`ifdef YSYX_23060201_ARB_RR_EN
      lsu_first = !m_last_lsu;
`else
      lsu_first = 1'b1;
`endif
      e_gl = !m_busy && lsu_req_valid && (!ifu_req_valid || lsu_first);
      e_gi = !m_busy && ifu_req_valid && !e_gl;
      e_mv = m_busy && !m_issued;
      hs   = e_mv && mem_req_ready;
      win  = m_busy && (m_issued || hs);
      chk("ifu_req_ready", ifu_req_ready, e_gi);
      chk("lsu_req_ready", lsu_req_ready, e_gl);
      chk("mem_req_valid", mem_req_valid, e_mv);
      if (e_mv) begin
        chk("mem_req_addr", mem_req_addr, m_addr);
        chk("mem_req_wdata", mem_req_wdata, m_wdata);
        chk("mem_req_wmask", mem_req_wmask, m_wmask);
        chk("mem_req_wen", mem_req_wen, m_wen);
      end
      chk("ifu_resp_valid", ifu_resp_valid, win && mem_resp_valid && !m_owner_lsu);
      chk("lsu_resp_valid", lsu_resp_valid, win && mem_resp_valid && m_owner_lsu);
      if (win && mem_resp_valid) begin
        if (m_owner_lsu) chk("lsu_resp_data", lsu_resp_data, mem_resp_data);
        else             chk("ifu_resp_data", ifu_resp_data, mem_resp_data);
      end
      if (m_busy) begin
        if (hs) m_issued = 1;
        if (win && mem_resp_valid) m_busy = 0;
      end else if (e_gl || e_gi) begin
        m_busy = 1; m_issued = 0; m_owner_lsu = e_gl; m_last_lsu = e_gl;
        m_addr  = e_gl ? lsu_req_addr : ifu_req_addr;
        m_wdata = e_gl ? lsu_req_wdata : '0;
        m_wmask = e_gl ? lsu_req_wmask : '0;
        m_wen   = e_gl ? lsu_req_wen : 1'b0;
        acc_ifu = e_gi;
        acc_lsu = e_gl;
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1;
    sample(); advance();
    sample();
    chk("rst_addr_zero", mem_req_addr, 0);
    chk("rst_wdata_zero", mem_req_wdata, 0);
    chk("rst_wmask_zero", mem_req_wmask, 0);
    chk("rst_wen_zero", mem_req_wen, 0);
    advance();
    rst = 0;
  endtask

  initial begin
    string got, exp_s;
    bit granted;
    int n;
    rst = 1;
    ifu_req_valid = 0; ifu_req_addr = 0;
    lsu_req_valid = 0; lsu_req_wen = 0; lsu_req_addr = 0; lsu_req_wdata = 0; lsu_req_wmask = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = 0;
    #1;

    // IFU fetch through a zero-wait memory.
    do_reset();
    ifu_req_valid = 1; ifu_req_addr = 32'h8000_0000; mem_req_ready = 1;
    sample(); chk("t32_ifu_ready_c0", ifu_req_ready, 1); advance();
    ifu_req_valid = 0;
    sample(); chk("t32_mem_valid_c1", mem_req_valid, 1); chk("t32_addr_c1", mem_req_addr, 32'h8000_0000); advance();
    mem_resp_valid = 1; mem_resp_data = 32'h0000_0413;
    sample();
    chk("t32_ifu_resp_c2", ifu_resp_valid, 1);
    chk("t32_ifu_data_c2", ifu_resp_data, 32'h0000_0413);
    chk("t32_lsu_resp_c2", lsu_resp_valid, 0);
    advance();
    mem_resp_valid = 0;
    sample(); chk("t32_mem_idle_c3", mem_req_valid, 0); advance();

    // LSU store with mem_req_ready held off for three cycles.
    do_reset();
    lsu_req_valid = 1; lsu_req_wen = 1; lsu_req_addr = 32'h8000_1000;
    lsu_req_wdata = 32'hDEAD_BEEF; lsu_req_wmask = 8'h0F; mem_req_ready = 0;
    sample(); chk("t33_lsu_ready", lsu_req_ready, 1); advance();
    lsu_req_valid = 0;
    for (int i = 0; i < 4; i++) begin
      mem_req_ready = (i == 3); mem_resp_valid = (i == 3); mem_resp_data = 0;
      sample();
      chk("t33_mem_valid", mem_req_valid, 1);
      chk("t33_addr", mem_req_addr, 32'h8000_1000);
      chk("t33_wdata", mem_req_wdata, 32'hDEAD_BEEF);
      chk("t33_wmask", mem_req_wmask, 8'h0F);
      chk("t33_wen", mem_req_wen, 1);
      chk("t33_lsu_resp", lsu_resp_valid, (i == 3));
      advance();
    end
    mem_req_ready = 0; mem_resp_valid = 0;
    sample(); chk("t33_back_idle", mem_req_valid, 0); advance();

    // Four contended grants.
    do_reset();
    got = "";
    for (int k = 0; k < 4; k++) begin
      ifu_req_valid = 1; ifu_req_addr = 32'h8000_0000 + 32'(k * 4);
      lsu_req_valid = 1; lsu_req_wen = 0; lsu_req_addr = 32'h8000_2000 + 32'(k * 4);
      lsu_req_wdata = 0; lsu_req_wmask = 0;
      mem_req_ready = 1; mem_resp_valid = 0;
      granted = 0; n = 0;
      while (!granted && n < 8) begin
        sample();
        if (ifu_req_ready || lsu_req_ready) begin
          got = {got, lsu_req_ready ? "L" : "I"};
          granted = 1;
        end
        advance();
        n++;
      end
      if (!granted) begin
        failures++;
        $display("FAIL t34_grant_timeout round=%0d", k);
      end
      sample(); advance();
      mem_resp_valid = 1; mem_resp_data = $urandom;
      sample(); advance();
      mem_resp_valid = 0;
    end
    ifu_req_valid = 0; lsu_req_valid = 0;
`ifdef YSYX_23060201_ARB_RR_EN
    exp_s = "LILI";
`else
    exp_s = "LLLL";
`endif
    checks++;
    if (got != exp_s) begin
      failures++;
      $display("FAIL t34_grant_order actual=%s required=%s", got, exp_s);
    end

    // Stray response while IDLE.
    do_reset();
    mem_resp_valid = 1; mem_resp_data = 32'h1234_5678;
    sample();
    chk("t35_ifu_resp", ifu_resp_valid, 0);
    chk("t35_lsu_resp", lsu_resp_valid, 0);
    chk("t35_mem_valid", mem_req_valid, 0);
    advance();
    mem_resp_valid = 0; ifu_req_valid = 1; ifu_req_addr = 32'h0000_0100;
    sample(); chk("t35_still_idle", ifu_req_ready, 1); advance();
    ifu_req_valid = 0; mem_req_ready = 1;
    sample(); advance();
    mem_resp_valid = 1;
    sample(); advance();
    mem_resp_valid = 0;

    // Reset in WAIT, then a late response.
    do_reset();
    ifu_req_valid = 1; ifu_req_addr = 32'h8000_0004; mem_req_ready = 1;
    sample(); advance();
    ifu_req_valid = 0;
    sample(); chk("t36_mem_valid", mem_req_valid, 1); advance();
    mem_req_ready = 0; rst = 1;
    sample(); advance();
    rst = 0; mem_resp_valid = 1; mem_resp_data = 32'h0000_0BAD;
    sample();
    chk("t36_ifu_resp_late", ifu_resp_valid, 0);
    chk("t36_lsu_resp_late", lsu_resp_valid, 0);
    chk("t36_mem_valid_idle", mem_req_valid, 0);
    advance();
    mem_resp_valid = 0; ifu_req_valid = 1; ifu_req_addr = 32'h8000_0008;
    sample(); chk("t36_next_ready", ifu_req_ready, 1); advance();
    ifu_req_valid = 0;
    sample(); chk("t36_next_addr", mem_req_addr, 32'h8000_0008); advance();
    mem_req_ready = 1; mem_resp_valid = 1;
    sample(); advance();
    mem_req_ready = 0; mem_resp_valid = 0;

    // Randomised traffic, random memory timing, stray responses and occasional resets.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      if (!ifu_req_valid && $urandom_range(0, 2) == 0) begin
        ifu_req_valid = 1; ifu_req_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!lsu_req_valid && $urandom_range(0, 2) == 0) begin
        lsu_req_valid = 1; lsu_req_wen = 1'($urandom_range(0, 1));
        lsu_req_addr = $urandom; lsu_req_wdata = $urandom; lsu_req_wmask = 8'($urandom);
      end
      mem_req_ready  = 1'($urandom_range(0, 1));
      mem_resp_valid = ($urandom_range(0, 2) == 0);
      mem_resp_data  = $urandom;
      sample();
      advance();
      if (acc_ifu) ifu_req_valid = 0;
      if (acc_lsu) lsu_req_valid = 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
